sdram_port_client: RTL

Synthesizable requester for one port of the multi-port `sdram` controller.
- Accepts user commands (write or read) on a valid/ready stream and buffers them in a command FIFO.
- Drives them onto the controller's port handshake, with one operation in flight at a time.
- Returns read data on a buffered valid/ready response stream.
- Sits between a user core (video fetch, CPU bridge) and one `port_*` slot of `sdram`.

---
 rtl/sdram_port_client_pkg.sv | 22 ++
 rtl/sdram_client_fifo.sv | 50 +++++
 rtl/sdram_port_client.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/sdram_port_client_pkg.sv
// Shared types for the sdram port client: FSM state encoding and command layout.
// Command words are packed in cmd_t field order: {we, addr, data, byte_en}.
package sdram_port_client_pkg;

    localparam int PKG_ADDR_WIDTH = 21;
    localparam int PKG_DATA_WIDTH = 32;
    localparam int PKG_DQM_WIDTH  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    typedef struct packed {
        logic                      we;
        logic [PKG_ADDR_WIDTH-1:0] addr;
        logic [PKG_DATA_WIDTH-1:0] data;
        logic [PKG_DQM_WIDTH-1:0]  byte_en;
    } cmd_t;

endpackage

// File: rtl/sdram_client_fifo.sv
// Generic synchronous FIFO; DEPTH must be a power of two so pointers wrap naturally.
// A push while full is accepted only when a pop happens in the same cycle.
module sdram_client_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

    // Storage needs no reset: dout is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/sdram_port_client.sv
// Single-outstanding requester for one port of the multi-port sdram controller.
// Optional macro SDRAM_PORT_CLIENT_STATS_EN adds completion/timeout counters.
module sdram_port_client
    import sdram_port_client_pkg::*;
#(
    parameter int PORT_ADDR_WIDTH = PKG_ADDR_WIDTH,
    parameter int DATA_WIDTH      = PKG_DATA_WIDTH,
    parameter int DQM_WIDTH       = PKG_DQM_WIDTH,
    parameter int CMD_DEPTH       = 4,
    parameter int RSP_DEPTH       = 4,
    parameter int TIMEOUT_CYCLES  = 4096
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_we,
    input  logic [PORT_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0]      cmd_data,
    input  logic [DQM_WIDTH-1:0]       cmd_byte_en,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [DATA_WIDTH-1:0]      rsp_data,
    output logic [PORT_ADDR_WIDTH-1:0] port_addr,
    output logic [DATA_WIDTH-1:0]      port_data,
    output logic [DQM_WIDTH-1:0]       port_byte_en,
    output logic                       port_wr,
    output logic                       port_rd,
    input  logic                       port_available,
    input  logic                       port_ready,
    input  logic [DATA_WIDTH-1:0]      port_q,
    output logic                       busy,
    output logic                       timeout_err,
    input  logic                       err_clr
`ifdef SDRAM_PORT_CLIENT_STATS_EN
    ,
    output logic [31:0]                wr_count,
    output logic [31:0]                rd_count,
    output logic [15:0]                timeout_count
`endif
);

    localparam int CMD_W = 1 + PORT_ADDR_WIDTH + DATA_WIDTH + DQM_WIDTH;
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    state_t                     state, state_next;
    logic [TMR_W-1:0]           tmr, tmr_next;
    logic                       wr_next, rd_next;
    logic [PORT_ADDR_WIDTH-1:0] addr_next;
    logic [DATA_WIDTH-1:0]      data_next;
    logic [DQM_WIDTH-1:0]       be_next;
    logic                       tmr_expired;

    logic [CMD_W-1:0]           cmd_in, cmd_head;
    logic                       cmd_push, cmd_pop, cmd_full, cmd_empty;
    logic [$clog2(CMD_DEPTH):0] cmd_count;
    logic                       head_we;
    logic [PORT_ADDR_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0]      head_data;
    logic [DQM_WIDTH-1:0]       head_be;

    logic                       rsp_push, rsp_pop, rsp_full, rsp_empty, rsp_free;
    logic [$clog2(RSP_DEPTH):0] rsp_count;

    assign cmd_in    = {cmd_we, cmd_addr, cmd_data, cmd_byte_en};
    assign cmd_push  = cmd_valid && cmd_ready;
    assign cmd_ready = !cmd_full;
    assign head_we   = cmd_head[CMD_W-1];
    assign head_addr = cmd_head[CMD_W-2 -: PORT_ADDR_WIDTH];
    assign head_data = cmd_head[DATA_WIDTH+DQM_WIDTH-1 -: DATA_WIDTH];
    assign head_be   = cmd_head[DQM_WIDTH-1:0];

    sdram_client_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (cmd_push),
        .din     (cmd_in),
        .pop     (cmd_pop),
        .dout    (cmd_head),
        .full    (cmd_full),
        .empty   (cmd_empty),
        .count   (cmd_count)
    );

    // A pop in the same cycle frees an entry, so a read may issue into a full FIFO then.
    assign rsp_pop   = rsp_valid && rsp_ready;
    assign rsp_valid = (rsp_count != '0);
    assign rsp_free  = !rsp_full || (rsp_ready && !rsp_empty);

    sdram_client_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (rsp_push),
        .din     (port_q),
        .pop     (rsp_pop),
        .dout    (rsp_data),
        .full    (rsp_full),
        .empty   (rsp_empty),
        .count   (rsp_count)
    );

    assign busy        = (state != IDLE) || !cmd_empty;
    assign tmr_expired = (state == ISSUE || state == WAIT) && (tmr == TMR_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            tmr          <= '0;
            port_wr      <= 1'b0;
            port_rd      <= 1'b0;
            port_addr    <= '0;
            port_data    <= '0;
            port_byte_en <= '0;
            timeout_err  <= 1'b0;
        end else begin
            state        <= state_next;
            tmr          <= tmr_next;
            port_wr      <= wr_next;
            port_rd      <= rd_next;
            port_addr    <= addr_next;
            port_data    <= data_next;
            port_byte_en <= be_next;
            timeout_err  <= tmr_expired || (timeout_err && !err_clr);
        end
    end

    // Timeout takes priority over acceptance and completion in the same cycle.
    always_comb begin
        state_next = state;
        tmr_next   = tmr;
        wr_next    = port_wr;
        rd_next    = port_rd;
        addr_next  = port_addr;
        data_next  = port_data;
        be_next    = port_byte_en;
        cmd_pop    = 1'b0;
        rsp_push   = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_count != '0 && (head_we || rsp_free)) begin
                    addr_next  = head_addr;
                    data_next  = head_data;
                    be_next    = head_be;
                    wr_next    = head_we;
                    rd_next    = !head_we;
                    tmr_next   = '0;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (tmr_expired) begin
                    wr_next    = 1'b0;
                    rd_next    = 1'b0;
                    cmd_pop    = 1'b1;
                    state_next = IDLE;
                end else begin
                    tmr_next = tmr + 1'b1;
                    if (port_available) begin
                        wr_next    = 1'b0;
                        rd_next    = 1'b0;
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (tmr_expired) begin
                    cmd_pop    = 1'b1;
                    state_next = IDLE;
                end else begin
                    tmr_next = tmr + 1'b1;
                    if (port_ready) begin
                        cmd_pop    = 1'b1;
                        rsp_push   = !head_we;
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                wr_next    = 1'b0;
                rd_next    = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

`ifdef SDRAM_PORT_CLIENT_STATS_EN
    logic completed;
    assign completed = (state == WAIT) && port_ready && !tmr_expired;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_count      <= '0;
            rd_count      <= '0;
            timeout_count <= '0;
        end else begin
            if (completed && head_we)  wr_count <= wr_count + 32'd1;
            if (completed && !head_we) rd_count <= rd_count + 32'd1;
            if (tmr_expired)           timeout_count <= timeout_count + 16'd1;
        end
    end
`endif

endmodule
